// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared PCIe PHY symbols, width codes and helpers
package pcie_phy_pkg;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;
  localparam logic [7:0] PAD = 8'hF7;

  typedef enum logic [1:0] {
    X1 = 2'd0,
    X2 = 2'd1,
    X4 = 2'd2,
    X8 = 2'd3
  } width_code_e;

  function automatic logic is_pkt_end(input logic [7:0] d, input logic dk);
    return dk && ((d == END) || (d == EDB));
  endfunction

endpackage

// File: rtl/byte_stripe_lanes_if.sv
// rtl/byte_stripe_lanes_if.sv - byte stream in, striped lane group out
interface byte_stripe_lanes_if #(
  parameter int NUM_LANES = 4
);

  logic [7:0]             D;
  logic                   DK;
  logic                   D_VALID;
  logic                   FLUSH;
  logic [1:0]             ACTIVE_WIDTH;
  logic [8*NUM_LANES-1:0] LANE;
  logic [NUM_LANES-1:0]   LANE_DK;
  logic                   LANE_VALID;
  logic                   GROUP_PADDED;

  modport master (
    output D, DK, D_VALID, FLUSH, ACTIVE_WIDTH,
    input  LANE, LANE_DK, LANE_VALID, GROUP_PADDED
  );

  modport slave (
    input  D, DK, D_VALID, FLUSH, ACTIVE_WIDTH,
    output LANE, LANE_DK, LANE_VALID, GROUP_PADDED
  );

endinterface

// File: rtl/lane_width_decode.sv
// rtl/lane_width_decode.sv - clamp link width code to a usable lane count
module lane_width_decode
  import pcie_phy_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [1:0] active_width,
  output logic [3:0] lane_count
);

  logic [3:0] full_count;

  always_comb begin
    full_count = 4'd8;
    case (width_code_e'(active_width))
      X1:      full_count = 4'd1;
      X2:      full_count = 4'd2;
      X4:      full_count = 4'd4;
      default: full_count = 4'd8;
    endcase
    lane_count = (full_count > 4'(NUM_LANES)) ? 4'(NUM_LANES) : full_count;
  end

endmodule

// File: rtl/byte_stripe_lanes.sv
// rtl/byte_stripe_lanes.sv - round-robin byte striper with PAD fill of partial groups
module byte_stripe_lanes
  import pcie_phy_pkg::*;
#(
  parameter int         NUM_LANES = 4,
  parameter logic [7:0] PAD_SYM   = PAD
) (
  input logic           CLK,
  input logic           RESET,
  byte_stripe_lanes_if.slave bus
);

  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [IW-1:0]          idx_q;
  logic [3:0]             width_q;
  logic [3:0]             width_dec;
  logic [8:0]             stage_q [NUM_LANES];

  logic [3:0]             idx_ext;
  logic [3:0]             fill;
  logic [3:0]             last_idx;
  logic                   done_full;
  logic                   done_end;
  logic                   done_flush;
  logic                   complete;
  logic [8*NUM_LANES-1:0] grp_lane;
  logic [NUM_LANES-1:0]   grp_dk;
  logic [8:0]             sym;

  lane_width_decode #(.NUM_LANES(NUM_LANES)) u_width_decode (
    .active_width (bus.ACTIVE_WIDTH),
    .lane_count   (width_dec)
  );

  // fill is the number of lanes holding real bytes once this cycle's byte lands
  assign idx_ext    = 4'(idx_q);
  assign fill       = idx_ext + {3'b000, bus.D_VALID};
  assign last_idx   = width_q - 4'd1;
  assign done_full  = bus.D_VALID && (idx_ext == last_idx);
  assign done_end   = bus.D_VALID && is_pkt_end(bus.D, bus.DK) && (idx_ext < last_idx);
  assign done_flush = bus.FLUSH && (fill != 4'd0) && !done_full && !done_end;
  assign complete   = done_full || done_end || done_flush;

  always_comb begin
    grp_lane = '0;
    grp_dk   = '0;
    sym      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (4'(i) >= width_q) begin
        sym = 9'h000;
      end else if (4'(i) < fill) begin
        // the closing byte bypasses the stage so the group emits on its own edge
        sym = (bus.D_VALID && (4'(i) == idx_ext)) ? {bus.DK, bus.D} : stage_q[i];
      end else begin
        sym = {1'b1, PAD_SYM};
      end
      grp_lane[8*i +: 8] = sym[7:0];
      grp_dk[i]          = sym[8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_q            <= '0;
      width_q          <= width_dec;
      bus.LANE         <= '0;
      bus.LANE_DK      <= '0;
      bus.LANE_VALID   <= 1'b0;
      bus.GROUP_PADDED <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      bus.LANE_VALID   <= complete;
      bus.GROUP_PADDED <= done_end || done_flush;
      if (bus.D_VALID) begin
        stage_q[idx_q] <= {bus.DK, bus.D};
      end
      if (complete) begin
        idx_q       <= '0;
        bus.LANE    <= grp_lane;
        bus.LANE_DK <= grp_dk;
      end else if (bus.D_VALID) begin
        idx_q <= idx_q + 1'b1;
      end
      // width only follows ACTIVE_WIDTH between groups
      if ((idx_q == '0) && !complete) begin
        width_q <= width_dec;
      end
    end
  end

endmodule

// File: tb/tb_byte_stripe_lanes.sv
// tb/tb_byte_stripe_lanes.sv - scoreboard bench for byte_stripe_lanes
module tb_byte_stripe_lanes;

  localparam int NL = 4;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  logic [36:0] exp_q [$];

  byte_stripe_lanes_if #(.NUM_LANES(NL)) bus ();

  byte_stripe_lanes #(.NUM_LANES(NL), .PAD_SYM(8'hF7)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    logic [36:0] got;
    logic [36:0] e;
    if (bus.LANE_VALID) begin
      got = {bus.GROUP_PADDED, bus.LANE_DK, bus.LANE};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got=%h", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL group got pad/dk/lane=%h expected=%h", got, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [7:0] b, input logic k);
    bus.D       = b;
    bus.DK      = k;
    bus.D_VALID = 1'b1;
    cyc();
    bus.D_VALID = 1'b0;
    bus.DK      = 1'b0;
    bus.D       = 8'h00;
  endtask

  task automatic expect_grp(input logic [31:0] l, input logic [3:0] k, input logic p);
    exp_q.push_back({p, k, l});
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  initial begin
    RESET            = 1'b1;
    bus.D            = 8'h00;
    bus.DK           = 1'b0;
    bus.D_VALID      = 1'b0;
    bus.FLUSH        = 1'b0;
    bus.ACTIVE_WIDTH = 2'd2;
    idle(2);
    check_val("reset_lane", bus.LANE, 32'h0);
    check_val("reset_lane_dk", {28'h0, bus.LANE_DK}, 32'h0);
    check_val("reset_valid", {31'h0, bus.LANE_VALID}, 32'h0);
    check_val("reset_padded", {31'h0, bus.GROUP_PADDED}, 32'h0);
    RESET = 1'b0;
    idle(1);

    // x4 full group
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    expect_grp(32'h04030201, 4'b0000, 0);
    send(8'h04, 0);

    // END closes a partial group
    send(8'hFB, 1); send(8'h11, 0);
    expect_grp(32'hF7FD11FB, 4'b1101, 1);
    send(8'hFD, 1);

    // x2 on four lanes
    bus.ACTIVE_WIDTH = 2'd1;
    idle(1);
    send(8'hA0, 0);
    expect_grp(32'h0000A1A0, 4'b0000, 0);
    send(8'hA1, 0);
    send(8'hA2, 0);
    expect_grp(32'h0000A3A2, 4'b0000, 0);
    send(8'hA3, 0);

    // gaps hold the partial group
    bus.ACTIVE_WIDTH = 2'd2;
    idle(1);
    send(8'h01, 0); idle(3);
    send(8'h02, 0); idle(1);
    send(8'h03, 0);
    expect_grp(32'h04030201, 4'b0000, 0);
    send(8'h04, 0);

    // FLUSH pads a partial group
    send(8'h55, 0); send(8'h66, 0);
    expect_grp(32'hF7F76655, 4'b1100, 1);
    bus.FLUSH = 1'b1; cyc(); bus.FLUSH = 1'b0;
    idle(1);

    // reset mid-group discards it
    send(8'h77, 0); send(8'h78, 0);
    RESET = 1'b1; cyc(); RESET = 1'b0;
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0);
    expect_grp(32'h40302010, 4'b0000, 0);
    send(8'h40, 0);

    // width change mid-group waits for the group to close
    send(8'h81, 0);
    bus.ACTIVE_WIDTH = 2'd1;
    send(8'h82, 0); send(8'h83, 0);
    expect_grp(32'h84838281, 4'b0000, 0);
    send(8'h84, 0);
    send(8'h91, 0);
    expect_grp(32'h00009291, 4'b0000, 0);
    send(8'h92, 0);

    // FLUSH on a completing byte gives one emission
    send(8'hC1, 0);
    expect_grp(32'h0000C2C1, 4'b0000, 0);
    bus.FLUSH = 1'b1; send(8'hC2, 0); bus.FLUSH = 1'b0;

    // x1: FLUSH alone is a no-op, END never pads
    bus.ACTIVE_WIDTH = 2'd0;
    idle(1);
    bus.FLUSH = 1'b1; cyc(); bus.FLUSH = 1'b0;
    expect_grp(32'h000000E5, 4'b0000, 0);
    send(8'hE5, 0);
    expect_grp(32'h000000FD, 4'b0001, 0);
    send(8'hFD, 1);

    // EDB as first byte of an x4 group
    bus.ACTIVE_WIDTH = 2'd2;
    idle(1);
    expect_grp(32'hF7F7F7FE, 4'b1111, 1);
    send(8'hFE, 1);

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_groups got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
